// File: rtl/chain_splitter_pkg.sv
// Shared types and defaults for the splitter-chain valve controller.
package chain_splitter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        DISPENSE,
        FLUSH,
        DONE
    } state_e;

    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_FLUSH_CYC  = 8;

    // Outlet index width; a 1-bit index is kept even for degenerate counts.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chain_splitter_ctrl_cycle_downcounter.sv
// Loadable down-counter shared by the timed states; holds at zero.
module cycle_downcounter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);
    assign last_o = (count_q == W'(1));

endmodule

// File: rtl/chain_splitter_ctrl.sv
// Dose sequencer: open one outlet valve, settle, pump, flush, report completion.
module chain_splitter_ctrl
    import chain_splitter_pkg::*;
#(
    parameter int N_OUT      = 128,
    parameter int IDX_W      = idx_w(N_OUT),
    parameter int VOL_W      = 16,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int FLUSH_CYC  = DEF_FLUSH_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_outlet,
    input  logic [VOL_W-1:0] req_vol,
    input  logic             abort,
    output logic [N_OUT-1:0] valve_en,
    output logic             pump_en,
    output logic             flush_en,
    output logic             done,
    output logic             err
);

    localparam logic [VOL_W-1:0] SETTLE_LD = VOL_W'(SETTLE_CYC);
    localparam logic [VOL_W-1:0] FLUSH_LD  = VOL_W'(FLUSH_CYC);
    localparam logic [IDX_W:0]   N_OUT_W   = (IDX_W + 1)'(N_OUT);

    state_e             state_q;
    logic [VOL_W-1:0]   vol_q;
    logic               ready_q;
    logic [N_OUT-1:0]   valve_q;
    logic               pump_q;
    logic               flush_q;
    logic               done_q;
    logic               err_q;

    logic               outlet_ok;
    logic [N_OUT-1:0]   onehot_d;
    logic               cnt_load;
    logic [VOL_W-1:0]   cnt_val;
    logic               cnt_zero;
    logic               cnt_last;
    logic               cnt_expire;

    assign outlet_ok  = ({1'b0, req_outlet} < N_OUT_W);
    assign cnt_expire = cnt_last | cnt_zero;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        onehot_d             = '0;
        onehot_d[req_outlet] = 1'b1;
    end

    // The single counter is reloaded on every entry into a timed state.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && outlet_ok) begin
                    cnt_load = 1'b1;
                    cnt_val  = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (abort || (cnt_expire && vol_q == '0)) begin
                    cnt_load = 1'b1;
                    cnt_val  = FLUSH_LD;
                end else if (cnt_expire) begin
                    cnt_load = 1'b1;
                    cnt_val  = vol_q;
                end
            end
            DISPENSE: begin
                if (abort || cnt_expire) begin
                    cnt_load = 1'b1;
                    cnt_val  = FLUSH_LD;
                end
            end
            default: ;
        endcase
    end

    cycle_downcounter #(
        .W(VOL_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .load_val_i(cnt_val),
        .dec_i     (1'b1),
        .zero_o    (cnt_zero),
        .last_o    (cnt_last)
    );

    // Outputs are registered alongside the state; async reset de-energises all drives at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vol_q   <= '0;
            ready_q <= 1'b1;
            valve_q <= '0;
            pump_q  <= 1'b0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        if (outlet_ok) begin
                            state_q <= SETTLE;
                            vol_q   <= req_vol;
                            ready_q <= 1'b0;
                            valve_q <= onehot_d;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (abort || (cnt_expire && vol_q == '0)) begin
                        state_q <= FLUSH;
                        flush_q <= 1'b1;
                    end else if (cnt_expire) begin
                        state_q <= DISPENSE;
                        pump_q  <= 1'b1;
                    end
                end
                DISPENSE: begin
                    if (abort || cnt_expire) begin
                        state_q <= FLUSH;
                        pump_q  <= 1'b0;
                        flush_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt_expire) begin
                        state_q <= DONE;
                        flush_q <= 1'b0;
                        valve_q <= '0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valve_q <= '0;
                    pump_q  <= 1'b0;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign valve_en  = valve_q;
    assign pump_en   = pump_q;
    assign flush_en  = flush_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_chain_splitter_ctrl.sv
// Self-checking bench: per-cycle dose timeline computed arithmetically from the dose rules.
module tb_chain_splitter_ctrl;

    localparam int S = 4;
    localparam int F = 8;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        abort;
    logic        sel;
    logic [6:0]  req_outlet;
    logic [15:0] req_vol;

    logic         ready_a, pump_a, flush_a, done_a, err_a;
    logic [127:0] valve_a;
    logic         ready_b, pump_b, flush_b, done_b, err_b;
    logic [99:0]  valve_b;

    logic         obs_ready, obs_pump, obs_flush, obs_done, obs_err;
    logic [127:0] obs_valve;

    int checks = 0;
    int errors = 0;

    chain_splitter_ctrl dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid && !sel),
        .req_ready (ready_a),
        .req_outlet(req_outlet),
        .req_vol   (req_vol),
        .abort     (abort && !sel),
        .valve_en  (valve_a),
        .pump_en   (pump_a),
        .flush_en  (flush_a),
        .done      (done_a),
        .err       (err_a)
    );

    // Narrow instance: non-power-of-two outlet count and a 6-bit volume.
    chain_splitter_ctrl #(
        .N_OUT(100),
        .VOL_W(6)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid && sel),
        .req_ready (ready_b),
        .req_outlet(req_outlet),
        .req_vol   (req_vol[5:0]),
        .abort     (abort && sel),
        .valve_en  (valve_b),
        .pump_en   (pump_b),
        .flush_en  (flush_b),
        .done      (done_b),
        .err       (err_b)
    );

    assign obs_ready = sel ? ready_b : ready_a;
    assign obs_pump  = sel ? pump_b  : pump_a;
    assign obs_flush = sel ? flush_b : flush_a;
    assign obs_done  = sel ? done_b  : done_a;
    assign obs_err   = sel ? err_b   : err_a;
    assign obs_valve = sel ? {28'd0, valve_b} : valve_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One dose on the selected instance. abort_off/kill_off are cycle offsets after the
    // accepting edge (0 = unused); hold keeps req_valid high with the next request staged.
    task automatic run_dose(input int outlet, input int vol, input int abort_off,
                            input int kill_off, input bit hold,
                            input int nxt_outlet, input int nxt_vol);
        int w;
        int flush_start;
        int done_k;
        logic [127:0] exp_valve;
        logic [127:0] lit_valve;
        w = 0;
        while (obs_ready !== 1'b1 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("ready_before_req", obs_ready, 1'b1);
        req_valid  = 1'b1;
        req_outlet = 7'(outlet);
        req_vol    = 16'(vol);
        @(posedge clk); #1;
        if (hold) begin
            req_outlet = 7'(nxt_outlet);
            req_vol    = 16'(nxt_vol);
        end else begin
            req_valid  = 1'b0;
            req_outlet = 7'($urandom);
            req_vol    = 16'($urandom);
        end
        flush_start = (abort_off > 0 && abort_off <= S + vol) ? abort_off + 1 : S + vol + 1;
        done_k      = flush_start + F;
        lit_valve   = '0;
        lit_valve[outlet] = 1'b1;
        for (int k = 1; k <= done_k + 1; k++) begin
            if (k == kill_off) begin
                #1 rst = 1'b1;
                #1;
                check("kill_valve", obs_valve, '0);
                check("kill_pump", obs_pump, 1'b0);
                check("kill_flush", obs_flush, 1'b0);
                check("kill_done", obs_done, 1'b0);
                check("kill_ready", obs_ready, 1'b1);
                rst       = 1'b0;
                abort     = 1'b0;
                req_valid = 1'b0;
                @(posedge clk); #1;
                return;
            end
            exp_valve = (k < done_k) ? lit_valve : '0;
            check($sformatf("valve o=%0d v=%0d T+%0d", outlet, vol, k), obs_valve, exp_valve);
            check($sformatf("pump o=%0d v=%0d T+%0d", outlet, vol, k), obs_pump,
                  (k >= S + 1 && k < flush_start));
            check($sformatf("flush o=%0d v=%0d T+%0d", outlet, vol, k), obs_flush,
                  (k >= flush_start && k < done_k));
            check($sformatf("done o=%0d v=%0d T+%0d", outlet, vol, k), obs_done, (k == done_k));
            check($sformatf("ready o=%0d v=%0d T+%0d", outlet, vol, k), obs_ready, (k > done_k));
            check($sformatf("err o=%0d v=%0d T+%0d", outlet, vol, k), obs_err, 1'b0);
            abort = (k == abort_off);
            if (k <= done_k) begin
                @(posedge clk); #1;
            end
        end
        abort = 1'b0;
    endtask

    initial begin
        int o;
        int v;
        int ab;
        rst        = 1'b1;
        req_valid  = 1'b0;
        abort      = 1'b0;
        sel        = 1'b0;
        req_outlet = '0;
        req_vol    = '0;
        #12;
        check("rst_ready", obs_ready, 1'b1);
        check("rst_valve", obs_valve, '0);
        check("rst_pump", obs_pump, 1'b0);
        check("rst_flush", obs_flush, 1'b0);
        check("rst_done", obs_done, 1'b0);
        check("rst_err", obs_err, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_dose(5, 10, 0, 0, 1'b0, 0, 0);
        run_dose(127, 0, 0, 0, 1'b0, 0, 0);
        run_dose(0, 1, 0, 0, 1'b0, 0, 0);

        // Illegal outlet on the 100-way instance.
        sel        = 1'b1;
        req_valid  = 1'b1;
        req_outlet = 7'd100;
        req_vol    = 16'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bad_err_pulse", obs_err, 1'b1);
        check("bad_valve", obs_valve, '0);
        check("bad_ready", obs_ready, 1'b1);
        check("bad_done", obs_done, 1'b0);
        for (int k = 2; k <= 20; k++) begin
            @(posedge clk); #1;
            check($sformatf("bad_err T+%0d", k), obs_err, 1'b0);
            check($sformatf("bad_done T+%0d", k), obs_done, 1'b0);
            check($sformatf("bad_valve T+%0d", k), obs_valve, '0);
            check($sformatf("bad_pump T+%0d", k), obs_pump, 1'b0);
        end
        run_dose(99, 63, 0, 0, 1'b0, 0, 0);
        sel = 1'b0;

        run_dose(17, 1000, 20, 0, 1'b0, 0, 0);
        run_dose(64, 12, 2, 0, 1'b0, 0, 0);
        run_dose(8, 3, S + 3 + 2, 0, 1'b0, 0, 0);
        run_dose(9, 0, S + 1, 0, 1'b0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            o  = int'($urandom_range(0, 127));
            v  = int'($urandom_range(0, 40));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, S + v + F)) : 0;
            run_dose(o, v, ab, 0, 1'b0, 0, 0);
        end

        run_dose(42, 50, 0, 12, 1'b0, 0, 0);
        run_dose(43, 7, 0, 0, 1'b0, 0, 0);

        run_dose(3, 5, 0, 0, 1'b1, 4, 6);
        run_dose(4, 6, 0, 0, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
